// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer.
// Holds the PC and produces the sequential and branch candidates for the
// PC-select mux. Fetches one instruction per PC from instruction memory and
// holds it for the decoder until execution is allowed to retire.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          OFFSET_W   = 8,
  parameter int          WORD_SHIFT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         next_pc,
  input  logic [OFFSET_W-1:0] offset,
  input  logic                stall,
  input  logic                imem_busywait,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         pc,
  output logic [31:0]         pc_plus4,
  output logic [31:0]         branch_target,
  output logic                imem_read,
  output logic [31:0]         imem_addr,
  output logic [31:0]         instr,
  output logic                instr_valid
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC} state_t;

  state_t      state, state_nxt;
  logic        capture;   // latch imem_rdata this edge
  logic        advance;   // retire: load next_pc this edge
  logic [31:0] off_ext;

  // Datapath: both mux candidates derive from the registered PC only.
  assign off_ext       = {{(32-OFFSET_W){offset[OFFSET_W-1]}}, offset};
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + (off_ext << WORD_SHIFT);
  assign imem_addr     = pc;

  // Next state and handshake; busywait is ignored in EXEC, stall outside it.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    advance   = 1'b0;
    imem_read = 1'b0;
    case (state)
      S_FETCH, S_WAIT: begin
        imem_read = ~reset;
        if (!imem_busywait) begin
          capture   = 1'b1;
          state_nxt = S_EXEC;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          advance   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // State, PC and instruction latch; reset drops any outstanding read at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (advance) begin
        pc          <= next_pc;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized scoreboard bench for pc_fetch_unit. Each instruction's expected
// PC, fetched word, mux candidates and successor PC are precomputed into a
// queue; a monitor pops one entry whenever a new instruction is presented.
module tb_pc_fetch_unit;
  localparam int N = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_pc;
  logic [7:0]  offset;
  logic        stall;
  logic        imem_busywait;
  logic [31:0] imem_rdata;
  logic [31:0] pc, pc_plus4, branch_target, imem_addr, instr;
  logic        imem_read, instr_valid;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .next_pc(next_pc), .offset(offset),
    .stall(stall), .imem_busywait(imem_busywait), .imem_rdata(imem_rdata),
    .pc(pc), .pc_plus4(pc_plus4), .branch_target(branch_target),
    .imem_read(imem_read), .imem_addr(imem_addr), .instr(instr),
    .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, instr, p4, bt, nxt;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  logic [31:0] tgt[N];
  logic [7:0]  offs[N];
  int          compared = 0;
  int          mismatched = 0;
  int          k = 0;
  int          cyc = 0;
  bit          run = 1'b0;
  bit          prev_v = 1'b0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0A0B_0C0D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (run) begin
      cyc++;
      if (instr_valid && !prev_v) begin
        if (q.size() == 0) begin
          chk("unexpected_instr", 32'd1, 32'd0);
        end else begin
          cur = q.pop_front();
          if (k == 0) chk("first_instr_latency", cyc, 1);
          chk("pc", pc, cur.pc);
          chk("instr", instr, cur.instr);
          chk("imem_addr", imem_addr, cur.pc);
          chk("pc_plus4", pc_plus4, cur.p4);
          chk("branch_target", branch_target, cur.bt);
          chk("imem_read_exec", {31'd0, imem_read}, 32'd0);
        end
      end else if (instr_valid) begin
        // stalled: everything frozen
        chk("pc_hold", pc, cur.pc);
        chk("instr_hold", instr, cur.instr);
        chk("imem_read_stall", {31'd0, imem_read}, 32'd0);
      end else if (prev_v) begin
        if (k == 0) chk("first_retire_latency", cyc, 2);
        chk("pc_next", pc, cur.nxt);
        chk("imem_read_fetch", {31'd0, imem_read}, 32'd1);
        k++;
      end else begin
        // fetching or waiting: PC constant, read held high
        if (k > 0) chk("pc_fetch_hold", pc, cur.nxt);
        chk("imem_read_wait", {31'd0, imem_read}, 32'd1);
      end
      prev_v = instr_valid;
    end
  end

  initial begin
    logic [31:0] mp, p4, bt, nxt, rnd;
    logic [7:0]  off;
    int          s, budget;

    // Reference: plain arithmetic on the program-order PC sequence.
    mp = 32'd0;
    for (int i = 0; i < N; i++) begin
      off = 8'($urandom);
      if (i == 4) off = 8'hFE;
      if (i == 7) off = 8'h7F;
      s   = int'($signed(off));
      p4  = mp + 32'd4;
      bt  = mp + 32'd4 + 32'(s * 4);
      rnd = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: nxt = p4;
        5, 6, 7:       nxt = bt;
        8:             nxt = rnd;
        default:       nxt = 32'hFFFF_FFFC;
      endcase
      if (i == 0) nxt = p4;
      if (i == 3) nxt = 32'h10;
      if (i == 4 || i == 7) nxt = bt;
      if (i == 6) nxt = 32'hFFFF_FFFC;
      if (i == 8) nxt = 32'h0000_0103;
      if (i == N - 1) nxt = 32'h40;
      offs[i] = off;
      tgt[i]  = nxt;
      q.push_back('{pc: mp, instr: mem(mp), p4: p4, bt: bt, nxt: nxt});
      mp = nxt;
    end

    // Reset state
    reset = 1'b1; stall = 1'b0; imem_busywait = 1'b0;
    imem_rdata = 32'hDEAD_BEEF; next_pc = 32'h1234_5678; offset = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_imem_read", {31'd0, imem_read}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);

    // Randomized run acting as instruction memory
    @(negedge clk);
    reset = 1'b0;
    run = 1'b1;
    budget = 0;
    while (k < N && budget < 4000) begin
      imem_busywait = (k == 0) ? 1'b0 : ($urandom_range(0, 9) < 4);
      stall         = (k == 0) ? 1'b0 : ($urandom_range(0, 9) < 3);
      imem_rdata    = imem_busywait ? $urandom : mem(imem_addr);
      next_pc       = tgt[k];
      offset        = offs[k];
      @(negedge clk);
      budget++;
    end
    if (k < N) chk("timeout_retired", k, N);

    // Async reset in the middle of a wait on memory, PC at 0x40
    imem_busywait = 1'b1; stall = 1'b0; imem_rdata = 32'hFFFF_0000;
    repeat (2) @(negedge clk);
    run = 1'b0;
    chk("wait_pc", pc, 32'h40);
    chk("wait_imem_read", {31'd0, imem_read}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_pc", pc, 32'd0);
    chk("async_valid", {31'd0, instr_valid}, 32'd0);
    chk("async_imem_read", {31'd0, imem_read}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    imem_busywait = 1'b0;
    imem_rdata = mem(32'd0);
    #1;
    chk("restart_addr", imem_addr, 32'd0);
    chk("restart_read", {31'd0, imem_read}, 32'd1);
    @(posedge clk);
    #1;
    chk("restart_valid", {31'd0, instr_valid}, 32'd1);
    chk("restart_instr", instr, mem(32'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
